// File: rtl/mod_updown_counter.sv
// Parametrised load/up/down counter: runtime modulus, wrap/saturate, prescaler,
// registered terminal-count pulse and sticky boundary flag. One-clock update latency.
module mod_updown_counter #(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               is_up,
  input  logic               load,
  input  logic [WIDTH-1:0]   in,
  input  logic [WIDTH-1:0]   max_val,
  input  logic               sat_mode,
  input  logic [PRESC_W-1:0] presc_div,
  input  logic               clr_flag,
  output logic [WIDTH-1:0]   count,
  output logic               tc,
  output logic               bnd_flag
);

  localparam logic [WIDTH-1:0]   C_ONE = WIDTH'(1);
  localparam logic [PRESC_W-1:0] P_ONE = PRESC_W'(1);

  logic [WIDTH-1:0]   r_count;
  logic [PRESC_W-1:0] r_pc;
  logic               r_tc;
  logic               r_flag;

  logic               w_step;
  logic               w_bnd;
  logic [WIDTH-1:0]   w_load_val;
  logic [WIDTH-1:0]   w_step_val;

  assign w_step     = !load && en && (r_pc == presc_div);
  assign w_load_val = (in > max_val) ? max_val : in;

  // ">=" on the up side covers max_val lowered below the current count at runtime
  always_comb begin
    w_bnd      = 1'b0;
    w_step_val = r_count;
    if (w_step) begin
      if (is_up) begin
        if (r_count >= max_val) begin
          w_bnd      = 1'b1;
          w_step_val = sat_mode ? max_val : '0;
        end else begin
          w_step_val = r_count + C_ONE;
        end
      end else begin
        if (r_count == '0) begin
          w_bnd      = 1'b1;
          w_step_val = sat_mode ? '0 : max_val;
        end else begin
          w_step_val = r_count - C_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_pc    <= '0;
      r_tc    <= 1'b0;
    end else if (load) begin
      r_count <= w_load_val;
      r_pc    <= '0;
      r_tc    <= 1'b0;
    end else if (en) begin
      r_pc    <= w_step ? '0 : r_pc + P_ONE;
      r_count <= w_step_val;
      r_tc    <= w_bnd;
    end else begin
      r_tc    <= 1'b0;
    end
  end

  // Set beats clear when both land on the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flag <= 1'b0;
    end else if (w_bnd) begin
      r_flag <= 1'b1;
    end else if (clr_flag) begin
      r_flag <= 1'b0;
    end
  end

  assign count    = r_count;
  assign tc       = r_tc;
  assign bnd_flag = r_flag;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed + random bench for mod_updown_counter (WIDTH=4): reference model feeds a scoreboard queue.
module tb_mod_updown_counter;

  localparam int W = 4;
  localparam int P = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0, is_up = 1'b1, load = 1'b0, sat_mode = 1'b0, clr_flag = 1'b0;
  logic [W-1:0] in = '0, max_val = 4'd9;
  logic [P-1:0] presc_div = '0;
  logic [W-1:0] count;
  logic         tc, bnd_flag;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [W-1:0] c;
    logic         t;
    logic         f;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state
  logic [W-1:0] m_count = '0;
  logic [P-1:0] m_pc = '0;
  logic         m_tc = 1'b0, m_flag = 1'b0;

  mod_updown_counter #(.WIDTH(W), .PRESC_W(P)) dut (
    .clk(clk), .rst(rst), .en(en), .is_up(is_up), .load(load), .in(in),
    .max_val(max_val), .sat_mode(sat_mode), .presc_div(presc_div),
    .clr_flag(clr_flag), .count(count), .tc(tc), .bnd_flag(bnd_flag)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic void model_reset();
    m_count = '0; m_pc = '0; m_tc = 1'b0; m_flag = 1'b0;
  endfunction

  // Advance the model by one edge using the currently driven inputs; push expectation
  function automatic void model_step();
    logic bnd;
    int   cnt_i, max_i;
    bnd   = 1'b0;
    cnt_i = int'(m_count);
    max_i = int'(max_val);
    if (load) begin
      m_count = (int'(in) > max_i) ? max_val : in;
      m_pc    = '0;
    end else if (en) begin
      if (m_pc == presc_div) begin
        m_pc = '0;
        if (is_up) begin
          if (cnt_i < max_i) m_count = W'(cnt_i + 1);
          else begin bnd = 1'b1; m_count = sat_mode ? max_val : '0; end
        end else begin
          if (cnt_i > 0) m_count = W'(cnt_i - 1);
          else begin bnd = 1'b1; m_count = sat_mode ? '0 : max_val; end
        end
      end else begin
        m_pc = m_pc + 1'b1;
      end
    end
    m_tc = bnd;
    if (bnd) m_flag = 1'b1;
    else if (clr_flag) m_flag = 1'b0;
    exp_q.push_back('{c: m_count, t: m_tc, f: m_flag});
  endfunction

  task automatic tick(input string tag);
    exp_t e;
    model_step();
    @(posedge clk);
    #1;
    checks++;
    assert (exp_q.size() > 0) else begin
      failures++;
      $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_count"}, int'(count), int'(e.c));
      chk({tag, "_tc"}, int'(tc), int'(e.t));
      chk({tag, "_flag"}, int'(bnd_flag), int'(e.f));
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", int'(count), 0);
    chk("rst_tc", int'(tc), 0);
    chk("rst_flag", int'(bnd_flag), 0);
    rst = 1'b0;
    model_reset();

    // Wrap up 0..9 then 0
    en = 1'b1; is_up = 1'b1; sat_mode = 1'b0; presc_div = 0; max_val = 4'd9;
    for (int i = 1; i <= 9; i++) begin
      tick("wrap_up");
      chk("wrap_up_seq", int'(count), i);
    end
    tick("wrap_edge");
    chk("wrap_to0", int'(count), 0);
    chk("wrap_tc", int'(tc), 1);
    chk("wrap_flag", int'(bnd_flag), 1);
    en = 1'b0;
    tick("tc_drop");
    chk("tc_one_cycle", int'(tc), 0);

    // Saturate down from 2
    load = 1'b1; in = 4'd2;
    tick("load2");
    load = 1'b0; en = 1'b1; is_up = 1'b0; sat_mode = 1'b1;
    tick("sat_dn1");
    tick("sat_dn0");
    tick("sat_hold1");
    chk("sat_hold_tc", int'(tc), 1);
    tick("sat_hold2");
    chk("sat_no_underflow", int'(count), 0);
    chk("sat_hold_tc2", int'(tc), 1);

    // Async reset mid-prescale with count=7, pc=2
    load = 1'b1; in = 4'd7; en = 1'b0;
    tick("load7");
    load = 1'b0; en = 1'b1; is_up = 1'b1; sat_mode = 1'b0; presc_div = 4'd3;
    tick("pc1");
    tick("pc2");
    chk("pre_rst_count", int'(count), 7);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_count", int'(count), 0);
    chk("async_rst_tc", int'(tc), 0);
    chk("async_rst_flag", int'(bnd_flag), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    tick("restart1");
    tick("restart2");
    tick("restart3");
    chk("restart_no_step", int'(count), 0);
    tick("restart4");
    chk("restart_step", int'(count), 1);

    // Prescaler hold with en low
    tick("pd_a");
    tick("pd_b");
    en = 1'b0;
    for (int i = 0; i < 5; i++) tick("pd_hold");
    en = 1'b1;
    tick("pd_c");
    tick("pd_d");
    chk("pd_resume", int'(count), 2);

    // Load clamp, load concurrent with prescaler match
    load = 1'b1; in = 4'd12; en = 1'b0;
    tick("load_clamp");
    chk("load_clamp_val", int'(count), 9);
    presc_div = 0; en = 1'b1;
    tick("load_vs_step");
    chk("load_no_step", int'(count), 9);
    chk("load_tc0", int'(tc), 0);
    load = 1'b0; presc_div = 4'd1;
    tick("post_load_pc");
    chk("post_load_hold", int'(count), 9);
    tick("post_load_step");
    chk("post_load_wrap", int'(count), 0);

    // Sticky flag: set wins over clear, then clear alone
    load = 1'b1; in = 4'd9;
    tick("load9");
    load = 1'b0; presc_div = 0; clr_flag = 1'b1;
    tick("clr_vs_set");
    chk("set_wins", int'(bnd_flag), 1);
    en = 1'b0;
    tick("clr_alone");
    chk("clr_done", int'(bnd_flag), 0);
    clr_flag = 1'b0;

    // max_val lowered below count, then max_val=0
    load = 1'b1; in = 4'd8;
    tick("load8");
    load = 1'b0; en = 1'b1; max_val = 4'd5; is_up = 1'b0;
    tick("lowered_dn");
    chk("lowered_dn_val", int'(count), 7);
    is_up = 1'b1;
    tick("lowered_up");
    chk("lowered_up_wrap", int'(count), 0);
    max_val = 4'd0;
    for (int i = 0; i < 3; i++) begin
      tick("max0");
      chk("max0_tc", int'(tc), 1);
    end

    // Random mix against the model
    for (int i = 0; i < 300; i++) begin
      en        = ($urandom_range(0, 9) != 0);
      is_up     = 1'($urandom_range(0, 1));
      load      = ($urandom_range(0, 15) == 0);
      in        = 4'($urandom_range(0, 15));
      sat_mode  = 1'($urandom_range(0, 1));
      clr_flag  = ($urandom_range(0, 7) == 0);
      presc_div = 4'($urandom_range(0, 2));
      if ($urandom_range(0, 19) == 0) max_val = 4'($urandom_range(0, 15));
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mod_updown_counter.md
Name: mod_updown_counter

Overview:
Parametrised successor to the team's load/up/down counter. Adds configurable width, a runtime modulus (max_val), wrap-or-saturate mode, a programmable prescaler, a terminal-count pulse and a sticky boundary flag. Used as a general event/timebase counter wherever the plain up/down counter is too narrow or lacks boundary reporting. Single clock domain.

Parameters:
WIDTH, 8, count/load/max_val width in bits (>=2)
PRESC_W, 4, prescaler divisor width in bits (>=1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
en  input  1  count enable; gates prescaler and counting
is_up  input  1  1 = count up, 0 = count down
load  input  1  synchronous load of in
in  input  WIDTH  load value
max_val  input  WIDTH  upper bound; count range is 0..max_val
sat_mode  input  1  1 = saturate at bounds, 0 = wrap
presc_div  input  PRESC_W  step every presc_div+1 enabled cycles
clr_flag  input  1  clears sticky bnd_flag
count  output  WIDTH  current count (registered)
tc  output  1  one-cycle terminal-count pulse (registered)
bnd_flag  output  1  sticky: a boundary event has occurred

Behaviour:
- Reset (async, active-high, any time incl. mid-prescale): count=0, tc=0, bnd_flag=0, internal prescaler counter pc=0. Outputs hold reset values while rst=1; first update on first rising clk after deassert.
- Priority per clock: rst > load > step > hold.
- load=1: count <= (in > max_val) ? max_val : in; pc <= 0; tc <= 0; no step that cycle. Load acts regardless of en.
- Prescaler (load=0, en=1): if pc==presc_div then pc<=0 and a step occurs this cycle; else pc<=pc+1, no step. en=0: pc and count hold, tc<=0. presc_div=0 -> step every enabled cycle. presc_div changed below current pc: pc continues to wrap at all-ones then matches; no special handling.
- Step up: count<max_val -> count+1. count>=max_val (boundary) -> wrap mode: count<=0; sat mode: count<=max_val. Boundary event raised.
- Step down: count>0 -> count-1. count==0 (boundary) -> wrap mode: count<=max_val; sat mode: count holds 0. Boundary event raised.
- Boundary event: tc=1 for exactly the cycle following the clock edge that processed it (registered), bnd_flag<=1. tc=0 on all other cycles. Consecutive boundary steps (sat mode, presc_div=0) give tc high continuously.
- max_val lowered below count at runtime: next up step is a boundary step (wrap to 0 / clamp to max_val); next down step decrements normally.
- max_val=0: count stays 0; every step is a boundary step, tc pulses per step.
- is_up / sat_mode may change any cycle; sampled on the step edge; pc unaffected.
- bnd_flag: clr_flag=1 clears it next edge; simultaneous boundary event and clr_flag -> flag set (set wins).
- Latency: count and tc update 1 clk after the enabling edge; no combinational path input->output.
- All arithmetic in WIDTH bits; no overflow beyond max_val is ever presented on count.

Test Plan:
- WIDTH=4, rst pulse mid-run with count=7, pc=2 -> count=0, tc=0, bnd_flag=0 immediately (async), counting restarts from pc=0.
- max_val=9, wrap, up, presc_div=0, en=1 from 0 -> 0..9, then 0; tc high one cycle with count=0 after 10th step; bnd_flag=1.
- max_val=9, sat, down from load in=2 -> 1, 0, 0, 0; tc high on each hold cycle after reaching 0; count never underflows to 15.
- presc_div=3, up from 0 -> count increments every 4th enabled cycle; deassert en for 5 cycles mid-period -> no step, pc resumes where held.
- load in=12 with max_val=9 -> count=9; load concurrent with en and prescaler match -> count=9, no step, pc=0.
- bnd_flag=1, assert clr_flag on same edge as a new wrap event -> bnd_flag stays 1; clr_flag alone next cycle -> bnd_flag=0.
